// File: rtl/ifu_fetch.sv
// In-order instruction fetch unit: credit-limited request issue, response buffer, redirect flush.
// Define IFU_MISALIGN_CHECK_EN to halt fetch on a misaligned redirect target (inst_misalign_o).
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i
`ifdef IFU_MISALIGN_CHECK_EN
   ,output logic        inst_misalign_o
`endif
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

`ifdef IFU_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL, S_HALT} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STALL} state_t;
`endif

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    state_t           state, state_nx, run_nx;
    logic [31:0]      fetch_pc, fetch_pc_nx;
    logic [31:0]      resp_pc, resp_pc_nx;
    logic [CNT_W-1:0] outstanding, out_nx;
    logic [CNT_W-1:0] discard, disc_nx;
    logic [CNT_W-1:0] count, cnt_nx;
    logic [CNT_W:0]   sum_nx;
    logic [PTR_W-1:0] rd_ptr, rd_nx, wr_ptr, wr_nx;
    entry_t           mem    [FIFO_DEPTH];
    entry_t           mem_nx [FIFO_DEPTH];
    logic             req_q, valid_q;
    entry_t           head_q;
    logic             fire, rvalid_live, push, pop, bad_target;
    logic [31:0]      target_pc;

    assign imem_req_o   = req_q;
    assign imem_addr_o  = fetch_pc;
    assign inst_valid_o = valid_q;
    assign inst_o       = head_q.inst;
    assign inst_pc_o    = head_q.pc;

`ifdef IFU_MISALIGN_CHECK_EN
    logic misalign_q;
    assign bad_target      = redirect_i & (redirect_pc_i[1:0] != 2'b00);
    assign inst_misalign_o = misalign_q;
`else
    logic unused_pc_lsbs;
    assign bad_target     = 1'b0;
    assign unused_pc_lsbs = ^redirect_pc_i[1:0];
`endif

    // Responses with nothing outstanding belong to a request abandoned by reset.
    assign fire        = req_q & imem_gnt_i;
    assign rvalid_live = imem_rvalid_i & (outstanding != '0);
    assign push        = rvalid_live & (discard == '0) & ~redirect_i;
    assign pop         = valid_q & inst_ready_i;
    assign target_pc   = {redirect_pc_i[31:2], 2'b00};

    // Next-state for counters, buffer and fetch PC.
    always_comb begin
        out_nx      = outstanding + CNT_W'(fire) - CNT_W'(rvalid_live);
        disc_nx     = discard;
        mem_nx      = mem;
        rd_nx       = rd_ptr;
        wr_nx       = wr_ptr;
        resp_pc_nx  = resp_pc;
        fetch_pc_nx = fetch_pc;

        if (redirect_i) begin
            disc_nx = out_nx;
        end else if (rvalid_live && (discard != '0)) begin
            disc_nx = discard - CNT_W'(1);
        end

        if (push) begin
            mem_nx[wr_ptr] = '{inst: imem_rdata_i, pc: resp_pc};
            wr_nx          = wr_ptr + PTR_W'(1);
            resp_pc_nx     = resp_pc + 32'd4;
        end
        if (pop) begin
            rd_nx = rd_ptr + PTR_W'(1);
        end
        cnt_nx = count + CNT_W'(push) - CNT_W'(pop);

        if (fire) begin
            fetch_pc_nx = fetch_pc + 32'd4;
        end

        if (redirect_i) begin
            rd_nx       = '0;
            wr_nx       = '0;
            cnt_nx      = '0;
            resp_pc_nx  = target_pc;
            fetch_pc_nx = target_pc;
        end

        sum_nx = (CNT_W + 1)'(out_nx) + (CNT_W + 1)'(cnt_nx);
        run_nx = (sum_nx < DEPTH_L) ? S_RUN : S_STALL;

        case (state)
            S_IDLE, S_RUN, S_STALL: state_nx = run_nx;
`ifdef IFU_MISALIGN_CHECK_EN
            S_HALT:                 state_nx = redirect_i ? run_nx : S_HALT;
`endif
            default:                state_nx = S_IDLE;
        endcase
        if (bad_target) begin
            state_nx = state_t'(2'd3);
        end
    end

    // State, counters, buffer and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= '{inst: NOP, pc: 32'h0};
            end
            req_q       <= 1'b0;
            valid_q     <= 1'b0;
            head_q      <= '{inst: NOP, pc: 32'h0};
`ifdef IFU_MISALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state       <= state_nx;
            fetch_pc    <= fetch_pc_nx;
            resp_pc     <= resp_pc_nx;
            outstanding <= out_nx;
            discard     <= disc_nx;
            count       <= cnt_nx;
            rd_ptr      <= rd_nx;
            wr_ptr      <= wr_nx;
            mem         <= mem_nx;
            req_q       <= (state_nx == S_RUN);
            valid_q     <= (cnt_nx != '0);
            head_q      <= mem_nx[rd_nx];
`ifdef IFU_MISALIGN_CHECK_EN
            if (bad_target) begin
                misalign_q <= 1'b1;
            end else if (redirect_i) begin
                misalign_q <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, is the instruction buffer entries; it is a power of two and at least 2.
REQ-003 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset, asynchronous and active-high.
REQ-005 imem_req_o  output  1  fetch request valid.
REQ-006 imem_addr_o  output  32  fetch word address; bits [1:0] are always 0.
REQ-007 imem_gnt_i  input  1  memory accepts the request this cycle.
REQ-008 imem_rvalid_i  input  1  read data valid; responses arrive in request order, at least 1 cycle after grant.
REQ-009 imem_rdata_i  input  32  instruction word.
REQ-010 redirect_i  input  1  branch or jump taken; restart fetch.
REQ-011 redirect_pc_i  input  32  restart address.
REQ-012 inst_valid_o  output  1  inst_o and inst_pc_o are valid toward decode.
REQ-013 inst_o  output  32  instruction to the control unit and decode.
REQ-014 inst_pc_o  output  32  address of inst_o.
REQ-015 inst_ready_i  input  1  decode consumes inst_o this cycle.
REQ-016 inst_misalign_o  output  1  misaligned redirect flag; exists only with IFU_MISALIGN_CHECK_EN.

Function
REQ-017 FSM states: IDLE, RUN, STALL and HALT; HALT is reachable only with the macro.
- IDLE is entered on reset and moves to RUN on the first clock.
REQ-018 A fetch is issued when the FSM is in RUN and outstanding + fifo_count < FIFO_DEPTH.
- In this condition imem_req_o=1 and imem_addr_o=fetch_pc.
REQ-019 When imem_req_o=1 and imem_gnt_i=1:
- fetch_pc advances by 4 (32-bit wrap-around, FFFF_FFFC goes to 0000_0000);
- outstanding increments.
REQ-020 imem_req_o and imem_addr_o stay stable while imem_req_o=1 and imem_gnt_i=0, unless redirect_i=1.
REQ-021 RUN goes to STALL when outstanding + fifo_count = FIFO_DEPTH; STALL returns to RUN when a slot frees.
REQ-022 On imem_rvalid_i=1 with discard=0, the {rdata, pc} pair is pushed into the FIFO, tagged with the PC of the oldest outstanding request.
- Outstanding decrements by 1.
REQ-023 inst_valid_o = FIFO not empty, and the FIFO head drives inst_o and inst_pc_o.
- Minimum latency is 1 cycle from rvalid to inst_valid_o.
REQ-024 The FIFO pops when inst_valid_o=1 and inst_ready_i=1.
- A push and a pop in the same cycle on a full FIFO are both legal.
REQ-025 When redirect_i=1, on that edge:
- the FIFO is flushed;
- fetch_pc is set to {redirect_pc_i[31:2], 2'b00};
- discard is set to the outstanding count, excluding any rvalid in the same cycle, which is itself dropped;
- inst_valid_o is 0 the next cycle.
REQ-026 While discard > 0, each imem_rvalid_i decrements discard and is dropped; issuing to the new PC continues concurrently.
REQ-027 A redirect in the same cycle as a grant counts the granted request as outstanding, to be discarded; a new request to the redirect PC is issued on the following cycle at the earliest.
REQ-028 Outstanding and discard counters are each clog2(FIFO_DEPTH)+1 bits wide and never overflow or underflow.

Reset
REQ-029 When rst_i=1, the block asynchronously sets:
- FSM to IDLE;
- fetch_pc=RESET_PC;
- FIFO empty;
- outstanding=0 and discard=0;
- imem_req_o=0, inst_valid_o=0, inst_o=32'h0000_0013 (NOP), inst_pc_o=0 and inst_misalign_o=0.
REQ-030 Reset asserted mid-transaction abandons all in-flight responses.
- Any rvalid after reset release with outstanding=0 is ignored.

Configuration
REQ-031 With IFU_MISALIGN_CHECK_EN defined, a redirect with redirect_pc_i[1:0]!=0 sets the FSM to HALT and inst_misalign_o=1, and issuing stops.
- Only a redirect with bits [1:0]=0 leaves HALT, clearing inst_misalign_o and going to RUN.
REQ-032 Without IFU_MISALIGN_CHECK_EN, inst_misalign_o and HALT do not exist and redirect_pc_i[1:0] are ignored.

Verification
REQ-033 Reset release with gnt=1 and rvalid 1 cycle later, ready=1 -> imem_addr_o 0,4,8,...; inst_pc_o 0,4,8 in order with matching rdata.
REQ-034 ready=0 for 10 cycles, DEPTH=2 -> exactly 2 grants, then imem_req_o=0 (STALL); ready=1 -> issuing resumes.
REQ-035 Redirect to 0x100 with 2 outstanding -> next 2 rvalids dropped; next inst_pc_o=0x100.
REQ-036 Redirect and rvalid in the same cycle -> that data is never presented; inst_valid_o=0 the next cycle.
REQ-037 rst_i pulsed mid-fetch with 1 outstanding -> all outputs at reset values immediately; the late rvalid is ignored; fetch restarts at RESET_PC.
REQ-038 With the macro, redirect to 0x102 -> inst_misalign_o=1 and no requests; redirect to 0x200 -> flag clears and fetch resumes at 0x200.
